// File: rtl/imem_pkg.sv
// Shared constants and fetch-state encoding for the instruction-memory responder.
// Optional build macro used by the IMEM files: IMEM_PARITY_EN.
package imem_pkg;

   localparam logic [31:0] IMEM_BASE  = 32'h0100_0000;
   localparam logic [31:0] IMEM_LAST  = 32'h0100_0FFC;
   localparam int          IMEM_DEPTH = 1024;
   localparam int          IMEM_AW    = 10;
   localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } fetch_state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction RAM: one synchronous write port, one registered read port, no reset.
// Read-before-write on address collision. Macro IMEM_PARITY_EN adds an even-parity bit per word.
module imem_array
   import imem_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int AW    = IMEM_AW
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
`ifdef IMEM_PARITY_EN
   output logic          o_rpar,
`endif
   output logic [31:0]   o_rdata
);

`ifdef IMEM_PARITY_EN
   localparam int MW = 33;
`else
   localparam int MW = 32;
`endif

   logic [MW-1:0] r_mem [DEPTH];
   logic [MW-1:0] r_rdata;
   logic [MW-1:0] w_wword;

`ifdef IMEM_PARITY_EN
   assign w_wword = {^i_wdata, i_wdata};
   assign o_rpar  = r_rdata[32];
`else
   assign w_wword = i_wdata;
`endif

   // Both updates are non-blocking, so a same-edge read sees the pre-write word.
   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= w_wword;
      if (i_re)
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata[31:0];

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch responder: range-checks a request, waits WAIT_CYCLES, returns word or fault.
// Optional macro IMEM_PARITY_EN enables stored parity and the parity_err output.
module imem_fetch_responder
   import imem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = IMEM_BASE,
   parameter int          DEPTH_WORDS = IMEM_DEPTH,
   parameter int          AW          = IMEM_AW,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] NOP_WORD    = imem_pkg::NOP_WORD
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic [31:0]   req_addr,
   output logic          req_ready,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_data,
   output logic          rsp_err,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [31:0]   prog_wdata,
`ifdef IMEM_PARITY_EN
   output logic          parity_err,
`endif
   output logic          busy
);

   localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd4;

   fetch_state_t  r_state;
   fetch_state_t  w_next;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_idx;
   logic          r_fault;

   logic          w_accept;
   logic          w_fault;
   logic [AW-1:0] w_idx;
   logic [AW-1:0] w_rd_idx;
   logic          w_enter_resp;
   logic [31:0]   w_rdata;
   logic          w_par_err;
   logic          w_bad;

   assign w_accept = req_valid & req_ready;
   assign w_fault  = (req_addr[1:0] != 2'b00) | (req_addr < BASE_ADDR) | (req_addr > LAST_ADDR);
   assign w_idx    = AW'((req_addr - BASE_ADDR) >> 2);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT:    if (r_cnt <= 4'd1) w_next = RESP;
         RESP:    if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_cnt   <= 4'(WAIT_CYCLES);
            r_idx   <= w_idx;
            r_fault <= w_fault;
         end else if (r_state == WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   // With zero wait states the RESP-entry read happens on the accept edge itself.
   assign w_enter_resp = (w_next == RESP) && (r_state != RESP);
   assign w_rd_idx     = (r_state == IDLE) ? w_idx : r_idx;

`ifdef IMEM_PARITY_EN
   logic w_rpar;

   imem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
      .clk     (clk),
      .i_we    (prog_we),
      .i_waddr (prog_addr),
      .i_wdata (prog_wdata),
      .i_re    (w_enter_resp),
      .i_raddr (w_rd_idx),
      .o_rpar  (w_rpar),
      .o_rdata (w_rdata)
   );

   assign w_par_err  = ~r_fault & (^{w_rpar, w_rdata});
   assign parity_err = (r_state == RESP) & w_par_err;
`else
   imem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
      .clk     (clk),
      .i_we    (prog_we),
      .i_waddr (prog_addr),
      .i_wdata (prog_wdata),
      .i_re    (w_enter_resp),
      .i_raddr (w_rd_idx),
      .o_rdata (w_rdata)
   );

   assign w_par_err = 1'b0;
`endif

   assign w_bad     = r_fault | w_par_err;
   assign req_ready = rst & (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_err   = (r_state == RESP) & w_bad;
   assign rsp_data  = (r_state != RESP) ? 32'd0 : (w_bad ? NOP_WORD : w_rdata);
   assign busy      = (r_state != IDLE);

endmodule
